// File: rtl/regbank_arb_pkg.sv
// Shared types and widths for the register-bank arbiter: FSM states, read-response
// owners, bank geometry and the starvation counter width.
package regbank_arb_pkg;

   localparam int REG_ADDR_W = 4;
   localparam int REG_DATA_W = 32;
   localparam int STARVE_W   = 8;

   typedef enum logic [1:0] {
      ARB_RUN    = 2'd0,
      ARB_DRAIN  = 2'd1,
      ARB_HALTED = 2'd2
   } arb_state_t;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CORE = 2'd1,
      OWN_HOST = 2'd2
   } owner_t;

   // Who will receive the bank's registered read data next cycle.
   function automatic owner_t read_owner(input logic core_gnt, input logic core_we,
                                         input logic host_gnt, input logic host_we);
      if (core_gnt && !core_we) return OWN_CORE;
      if (host_gnt && !host_we) return OWN_HOST;
      return OWN_NONE;
   endfunction

endpackage

// File: rtl/regbank_arbiter_if.sv
// Bundle of the core request port, host request/halt port and the bank-side port
// of the register-bank arbiter.
interface regbank_arbiter_if
   import regbank_arb_pkg::*;
#(
   parameter int ADDR_W = REG_ADDR_W,
   parameter int DATA_W = REG_DATA_W
) ();

   // Handshake: a request transfers in the cycle where valid and ready are both 1.
   // Requesters hold valid and payload stable until that cycle; ready may depend
   // combinationally on valid. rvalid is a one-cycle pulse with no back-pressure.
   logic              core_valid;
   logic              core_we;
   logic [ADDR_W-1:0] core_a1;
   logic [ADDR_W-1:0] core_a2;
   logic [ADDR_W-1:0] core_a3;
   logic [DATA_W-1:0] core_wd;
   logic              core_ready;
   logic              core_rvalid;
   logic [DATA_W-1:0] core_rd1;
   logic [DATA_W-1:0] core_rd2;

   logic              host_valid;
   logic              host_we;
   logic [ADDR_W-1:0] host_a1;
   logic [ADDR_W-1:0] host_a2;
   logic [ADDR_W-1:0] host_a3;
   logic [DATA_W-1:0] host_wd;
   logic              host_ready;
   logic              host_rvalid;
   logic [DATA_W-1:0] host_rd1;
   logic [DATA_W-1:0] host_rd2;
   logic              host_halt;
   logic              host_halted;

   logic [ADDR_W-1:0] rb_a1;
   logic [ADDR_W-1:0] rb_a2;
   logic [ADDR_W-1:0] rb_a3;
   logic              rb_we3;
   logic [DATA_W-1:0] rb_wd3;
   logic [DATA_W-1:0] rb_rd1;
   logic [DATA_W-1:0] rb_rd2;

   modport slave (
      input  core_valid, core_we, core_a1, core_a2, core_a3, core_wd,
      output core_ready, core_rvalid, core_rd1, core_rd2,
      input  host_valid, host_we, host_a1, host_a2, host_a3, host_wd,
      output host_ready, host_rvalid, host_rd1, host_rd2,
      input  host_halt,
      output host_halted,
      output rb_a1, rb_a2, rb_a3, rb_we3, rb_wd3,
      input  rb_rd1, rb_rd2
   );

   modport master (
      output core_valid, core_we, core_a1, core_a2, core_a3, core_wd,
      input  core_ready, core_rvalid, core_rd1, core_rd2,
      output host_valid, host_we, host_a1, host_a2, host_a3, host_wd,
      input  host_ready, host_rvalid, host_rd1, host_rd2,
      output host_halt,
      input  host_halted,
      input  rb_a1, rb_a2, rb_a3, rb_we3, rb_wd3,
      output rb_rd1, rb_rd2
   );

endinterface

// File: rtl/regbank_starve_ctr.sv
// Saturating wait counter: counts host cycles spent waiting behind the core and
// flags when the wait has reached the configured limit.
module regbank_starve_ctr
   import regbank_arb_pkg::*;
#(
   parameter int W = STARVE_W
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         inc_i,
   input  logic         clr_i,
   input  logic [W-1:0] limit_i,
   output logic         at_limit_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q < limit_i)) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign at_limit_o = (cnt_q == limit_i);

endmodule

// File: rtl/regbank_arbiter.sv
// Arbiter between the core and the host/loader for the shared 16x32 register bank,
// with host halt/exclusive ownership and routing of registered read data.
module regbank_arbiter
   import regbank_arb_pkg::*;
#(
   parameter int STARVE_LIMIT = 8,
   parameter int ADDR_W       = REG_ADDR_W,
   parameter int DATA_W       = REG_DATA_W
) (
   input  logic             clk,
   input  logic             rst,
   regbank_arbiter_if.slave bus,
   output arb_state_t       state_o
);

   arb_state_t        state_q, state_d;
   owner_t            owner_q, owner_d;
   logic              core_gnt, host_gnt;
   logic              starve_inc, starve_clr, starve_at_limit;
   logic              we_d;
   logic [ADDR_W-1:0] a1_d, a2_d, a3_d;
   logic [DATA_W-1:0] wd_d;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ARB_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ARB_RUN:    if (bus.host_halt) state_d = ARB_DRAIN;
         ARB_DRAIN:  state_d = bus.host_halt ? ARB_HALTED : ARB_RUN;
         ARB_HALTED: if (!bus.host_halt) state_d = ARB_RUN;
         default:    state_d = ARB_RUN;
      endcase
   end

   // ---------------- FSM: outputs (grants) ----------------
   // A halt request blocks the core in the very cycle it rises; the drain cycle
   // lets the last read response land before the host takes the bank.
   always_comb begin
      core_gnt = 1'b0;
      host_gnt = 1'b0;
      if (rst) begin
         case (state_q)
            ARB_RUN: begin
               if (!bus.host_halt) begin
                  if (bus.host_valid && starve_at_limit) begin
                     host_gnt = 1'b1;
                  end else if (bus.core_valid) begin
                     core_gnt = 1'b1;
                  end else if (bus.host_valid) begin
                     host_gnt = 1'b1;
                  end
               end
            end
            ARB_HALTED: host_gnt = bus.host_valid;
            default: ;
         endcase
      end
   end

   assign bus.core_ready  = core_gnt;
   assign bus.host_ready  = host_gnt;
   assign bus.host_halted = (state_q == ARB_HALTED);
   assign state_o         = state_q;

   // ---------------- Bank request mux ----------------
   always_comb begin
      we_d = 1'b0;
      a1_d = '0;
      a2_d = '0;
      a3_d = '0;
      wd_d = '0;
      if (core_gnt) begin
         we_d = bus.core_we;
         a1_d = bus.core_a1;
         a2_d = bus.core_a2;
         a3_d = bus.core_a3;
         wd_d = bus.core_wd;
      end else if (host_gnt) begin
         we_d = bus.host_we;
         a1_d = bus.host_a1;
         a2_d = bus.host_a2;
         a3_d = bus.host_a3;
         wd_d = bus.host_wd;
      end
   end

   assign bus.rb_we3 = we_d;
   assign bus.rb_a1  = a1_d;
   assign bus.rb_a2  = a2_d;
   assign bus.rb_a3  = a3_d;
   assign bus.rb_wd3 = wd_d;

   // ---------------- Host starvation guard ----------------
   // Only waiting in ARB_RUN counts; the drain cycle neither counts nor clears.
   assign starve_inc = rst && (state_q == ARB_RUN) && bus.host_valid && !host_gnt;
   assign starve_clr = !bus.host_valid || host_gnt;

   regbank_starve_ctr #(
      .W (STARVE_W)
   ) u_starve_ctr (
      .clk_i      (clk),
      .rst_i      (rst),
      .inc_i      (starve_inc),
      .clr_i      (starve_clr),
      .limit_i    (STARVE_W'(STARVE_LIMIT)),
      .at_limit_o (starve_at_limit)
   );

   // ---------------- Read response routing ----------------
   always_comb begin
      owner_d = read_owner(core_gnt, bus.core_we, host_gnt, bus.host_we);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         owner_q <= OWN_NONE;
      end else begin
         owner_q <= owner_d;
      end
   end

   assign bus.core_rvalid = (owner_q == OWN_CORE);
   assign bus.host_rvalid = (owner_q == OWN_HOST);
   assign bus.core_rd1    = bus.core_rvalid ? bus.rb_rd1 : '0;
   assign bus.core_rd2    = bus.core_rvalid ? bus.rb_rd2 : '0;
   assign bus.host_rd1    = bus.host_rvalid ? bus.rb_rd1 : '0;
   assign bus.host_rd2    = bus.host_rvalid ? bus.rb_rd2 : '0;

endmodule

// File: tb/tb_regbank_arbiter.sv
// Self-checking bench for regbank_arbiter: table of single-cycle arbitration vectors
// plus hand sequences for reset, starvation, halt/drain and reset-while-halted.
module tb_regbank_arbiter;
   import regbank_arb_pkg::*;

   localparam int LIMIT = 4;
   localparam int SB_W  = 2 + 2 * REG_DATA_W;

   typedef struct {
      logic        valid;
      logic        we;
      logic [3:0]  a1;
      logic [3:0]  a2;
      logic [3:0]  a3;
      logic [31:0] wd;
   } req_t;

   typedef struct {
      string name;
      req_t  c;
      req_t  h;
      logic  ec;
      logic  eh;
   } vec_t;

   // ---------------- clock / reset ----------------
   logic       clk;
   logic       rst;
   arb_state_t state_o;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   regbank_arbiter_if #(.ADDR_W(REG_ADDR_W), .DATA_W(REG_DATA_W)) bus ();

   regbank_arbiter #(
      .STARVE_LIMIT (LIMIT),
      .ADDR_W       (REG_ADDR_W),
      .DATA_W       (REG_DATA_W)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus.slave),
      .state_o (state_o)
   );

   // Bank model: write on the falling edge, registered read on the rising edge.
   logic [31:0] bank_mem [16] = '{default: '0};
   always @(negedge clk) begin
      if (bus.rb_we3 === 1'b1) bank_mem[bus.rb_a3] <= bus.rb_wd3;
   end
   always @(posedge clk) begin
      bus.rb_rd1 <= bank_mem[bus.rb_a1];
      bus.rb_rd2 <= bank_mem[bus.rb_a2];
   end

   // ---------------- scoreboard state ----------------
   logic [31:0]     shadow [16];
   logic [SB_W-1:0] exp_q [$];
   logic [SB_W-1:0] mon_e, mon_a;
   int              checks;
   int              failures;
   req_t            cur_c, cur_h, idle_req;
   vec_t            tbl [$];

   task automatic chk(input string name, input logic [SB_W-1:0] act, input logic [SB_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   function automatic req_t mkreq(input logic v, input logic we, input logic [3:0] a1,
                                  input logic [3:0] a2, input logic [3:0] a3, input logic [31:0] wd);
      req_t r;
      r.valid = v; r.we = we; r.a1 = a1; r.a2 = a2; r.a3 = a3; r.wd = wd;
      return r;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic drive(input req_t c, input req_t h, input logic halt);
      cur_c = c;
      cur_h = h;
      bus.core_valid = c.valid; bus.core_we = c.we;
      bus.core_a1 = c.a1; bus.core_a2 = c.a2; bus.core_a3 = c.a3; bus.core_wd = c.wd;
      bus.host_valid = h.valid; bus.host_we = h.we;
      bus.host_a1 = h.a1; bus.host_a2 = h.a2; bus.host_a3 = h.a3; bus.host_wd = h.wd;
      bus.host_halt = halt;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Check grants and bank-side outputs for this cycle against the requester the
   // bench expects to win; record the effect of the granted transaction.
   task automatic expect_cycle(input string name, input logic ec, input logic eh);
      req_t        g;
      logic [44:0] exp_bus, act_bus;
      #3;
      chk({name, ".core_ready"}, SB_W'(bus.core_ready), SB_W'(ec));
      chk({name, ".host_ready"}, SB_W'(bus.host_ready), SB_W'(eh));
      if (ec) g = cur_c;
      else if (eh) g = cur_h;
      else g = idle_req;
      exp_bus = {g.we, g.a1, g.a2, g.a3, g.wd};
      act_bus = {bus.rb_we3, bus.rb_a1, bus.rb_a2, bus.rb_a3, bus.rb_wd3};
      chk({name, ".rb"}, SB_W'(act_bus), SB_W'(exp_bus));
      if (ec || eh) begin
         if (g.we) shadow[g.a3] = g.wd;
         else exp_q.push_back({ec, eh, shadow[g.a1], shadow[g.a2]});
      end
   endtask

   task automatic run_cycle(input string name, input req_t c, input req_t h,
                            input logic halt, input logic ec, input logic eh);
      step();
      drive(c, h, halt);
      expect_cycle(name, ec, eh);
   endtask

   task automatic add(input string name, input req_t c, input req_t h, input logic ec, input logic eh);
      vec_t v;
      v.name = name; v.c = c; v.h = h; v.ec = ec; v.eh = eh;
      tbl.push_back(v);
   endtask

   // ---------------- response monitor ----------------
   always begin
      @(posedge clk);
      #3;
      if (rst !== 1'b1) begin
         exp_q.delete();
      end else begin
         mon_a = {bus.core_rvalid, bus.host_rvalid,
                  bus.core_rvalid ? {bus.core_rd1, bus.core_rd2} : {bus.host_rd1, bus.host_rd2}};
         mon_e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
         chk("resp", mon_a, mon_e);
         if (bus.core_rvalid !== 1'b1) chk("core_rd_idle", SB_W'({bus.core_rd1, bus.core_rd2}), '0);
         if (bus.host_rvalid !== 1'b1) chk("host_rd_idle", SB_W'({bus.host_rd1, bus.host_rd2}), '0);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- test sequence ----------------
   initial begin
      req_t c_rd, h_wr, c_alt;
      checks   = 0;
      failures = 0;
      rst      = 1'b0;
      idle_req = mkreq(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 32'd0);
      for (int i = 0; i < 16; i++) shadow[i] = '0;
      drive(idle_req, idle_req, 1'b0);

      // Reset held with live write requests: nothing may reach the bank.
      run_cycle("rst_hold0", mkreq(1, 1, 0, 0, 1, 32'hBAD0_BAD0), mkreq(1, 1, 0, 0, 2, 32'h5A5A_5A5A), 0, 0, 0);
      run_cycle("rst_hold1", mkreq(1, 1, 0, 0, 1, 32'hBAD0_BAD0), mkreq(1, 1, 0, 0, 2, 32'h5A5A_5A5A), 0, 0, 0);
      step();
      rst = 1'b1;
      drive(idle_req, idle_req, 1'b0);
      expect_cycle("rst_idle", 0, 0);
      chk("rst_halted", SB_W'(bus.host_halted), '0);
      chk("rst_state", SB_W'(state_o), SB_W'(ARB_RUN));

      // Single-cycle arbitration vectors (starvation counter never reaches LIMIT here).
      add("h_wr_r3",     idle_req,                                 mkreq(1, 1, 0, 0, 3, 32'h0000_0011), 0, 1);
      add("h_wr_r5",     idle_req,                                 mkreq(1, 1, 0, 0, 5, 32'h0000_0022), 0, 1);
      add("c_wr_over_h", mkreq(1, 1, 0, 0, 10, 32'hA5A5_0000),     mkreq(1, 1, 0, 0, 9, 32'h1234_5678), 1, 0);
      add("c_rd_3_5",    mkreq(1, 0, 3, 5, 0, 32'h0BAD_F00D),      mkreq(1, 1, 0, 0, 9, 32'h1234_5678), 1, 0);
      add("h_wr_r9",     idle_req,                                 mkreq(1, 1, 0, 0, 9, 32'h1234_5678), 0, 1);
      add("c_rd_9_10",   mkreq(1, 0, 9, 10, 7, 32'h0000_0001),     mkreq(1, 0, 3, 9, 0, 32'h0), 1, 0);
      add("h_rd_3_9",    idle_req,                                 mkreq(1, 0, 3, 9, 0, 32'hFEED_0000), 0, 1);
      add("idle",        idle_req,                                 idle_req, 0, 0);
      add("h_rd_10_1",   idle_req,                                 mkreq(1, 0, 10, 1, 0, 32'h0), 0, 1);
      add("c_wr_r15",    mkreq(1, 1, 0, 0, 15, 32'hFFFF_FFFF),     idle_req, 1, 0);
      add("c_rd_15_9",   mkreq(1, 0, 15, 9, 0, 32'h0),             idle_req, 1, 0);
      add("idle_end",    idle_req,                                 idle_req, 0, 0);
      for (int i = 0; i < tbl.size(); i++) begin
         run_cycle(tbl[i].name, tbl[i].c, tbl[i].h, 1'b0, tbl[i].ec, tbl[i].eh);
      end

      // Starvation: LIMIT core grants, then the waiting host write is forced through.
      c_rd = mkreq(1, 0, 3, 5, 0, 32'h0);
      h_wr = mkreq(1, 1, 0, 0, 2, 32'hDEAD_BEEF);
      for (int i = 0; i < LIMIT; i++) run_cycle("starve_core", c_rd, h_wr, 0, 1, 0);
      run_cycle("starve_host", c_rd, h_wr, 0, 0, 1);
      run_cycle("starve_core_after", c_rd, idle_req, 0, 1, 0);
      run_cycle("rd_r2_after_starve", mkreq(1, 0, 2, 5, 0, 32'h0), idle_req, 0, 1, 0);

      // Halt raised while a core read response is outstanding.
      c_alt = mkreq(1, 0, 9, 10, 0, 32'h0);
      run_cycle("pre_halt_rd", mkreq(1, 0, 5, 3, 0, 32'h0), idle_req, 0, 1, 0);
      run_cycle("halt_rise", c_alt, idle_req, 1, 0, 0);
      chk("halt_rise.state", SB_W'(state_o), SB_W'(ARB_RUN));
      run_cycle("drain", c_alt, idle_req, 1, 0, 0);
      chk("drain.state", SB_W'(state_o), SB_W'(ARB_DRAIN));
      chk("drain.halted", SB_W'(bus.host_halted), '0);
      run_cycle("halted_enter", c_alt, idle_req, 1, 0, 0);
      chk("halted_enter.halted", SB_W'(bus.host_halted), SB_W'(1'b1));
      chk("halted_enter.state", SB_W'(state_o), SB_W'(ARB_HALTED));

      // Exclusive host access; core keeps requesting and must be held off.
      run_cycle("halted_h_wr_r7", c_alt, mkreq(1, 1, 0, 0, 7, 32'hCAFE_0001), 1, 0, 1);
      run_cycle("halted_h_rd_7_2", c_alt, mkreq(1, 0, 7, 2, 0, 32'h0), 1, 0, 1);
      run_cycle("halted_idle", c_alt, idle_req, 1, 0, 0);
      chk("halted_idle.halted", SB_W'(bus.host_halted), SB_W'(1'b1));
      run_cycle("halt_drop", c_alt, idle_req, 0, 0, 0);
      chk("halt_drop.state", SB_W'(state_o), SB_W'(ARB_HALTED));
      run_cycle("run_resume", c_alt, idle_req, 0, 1, 0);
      chk("run_resume.state", SB_W'(state_o), SB_W'(ARB_RUN));

      // Halt dropped during the drain cycle returns straight to ARB_RUN.
      run_cycle("halt_pulse", idle_req, idle_req, 1, 0, 0);
      run_cycle("drain_drop", idle_req, mkreq(1, 0, 7, 9, 0, 32'h0), 0, 0, 0);
      chk("drain_drop.state", SB_W'(state_o), SB_W'(ARB_DRAIN));
      run_cycle("after_drain", idle_req, mkreq(1, 0, 7, 9, 0, 32'h0), 0, 0, 1);
      chk("after_drain.state", SB_W'(state_o), SB_W'(ARB_RUN));

      // Reset while halted with a host read response pending.
      run_cycle("rh_halt", idle_req, idle_req, 1, 0, 0);
      run_cycle("rh_drain", idle_req, idle_req, 1, 0, 0);
      run_cycle("rh_h_rd", idle_req, mkreq(1, 0, 7, 3, 0, 32'h0), 1, 0, 1);
      chk("rh_h_rd.state", SB_W'(state_o), SB_W'(ARB_HALTED));
      step();
      rst = 1'b0;
      drive(idle_req, mkreq(1, 1, 0, 0, 4, 32'h0BAD_0BAD), 1'b1);
      expect_cycle("rh_rst", 0, 0);
      step();
      rst = 1'b1;
      drive(idle_req, idle_req, 1'b0);
      expect_cycle("rh_after", 0, 0);
      chk("rh_after.halted", SB_W'(bus.host_halted), '0);
      chk("rh_after.rvalid", SB_W'(bus.host_rvalid), '0);
      chk("rh_after.state", SB_W'(state_o), SB_W'(ARB_RUN));

      // Confirm the write offered during reset never landed.
      run_cycle("rd_r4_after_rst", mkreq(1, 0, 4, 7, 0, 32'h0), idle_req, 0, 1, 0);
      run_cycle("final_idle", idle_req, idle_req, 0, 0, 0);
      step();
      #3;
      chk("sb_empty", SB_W'(exp_q.size()), '0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
